// File: rtl/sram_arb_pkg.sv
// Shared widths, FSM state type and address helper for the background-fetch SRAM arbiter.
package sram_arb_pkg;

    localparam int unsigned SRAM_AW = 20;
    localparam int unsigned SRAM_DW = 16;
    localparam int unsigned DISP_AW = 19;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWrSetup,
        StWr,
        StWrHold
    } arb_state_e;

    // Word address of a pixel: two pixels share one 16-bit word.
    function automatic logic [SRAM_AW-1:0] pixel_word_addr(
        input logic [SRAM_AW-1:0] base,
        input logic [DISP_AW-1:0] pix
    );
        return base + {{(SRAM_AW - DISP_AW + 1){1'b0}}, pix[DISP_AW-1:1]};
    endfunction

endpackage

// File: rtl/sram_io_buf.sv
// Tristate driver for the SRAM data bus with a capture register for read data.
module sram_io_buf
    import sram_arb_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               oe_i,
    input  logic [SRAM_DW-1:0] wdata_i,
    input  logic               capture_i,
    output logic [SRAM_DW-1:0] rdata_o,
    inout  wire  [SRAM_DW-1:0] dq_io
);

    logic [SRAM_DW-1:0] rdata_q, rdata_d;

    assign dq_io = oe_i ? wdata_i : {SRAM_DW{1'bz}};

    always_comb begin
        rdata_d = rdata_q;
        if (capture_i) begin
            rdata_d = dq_io;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_bg_fetch_arbiter.sv
// Background-image SRAM owner: strict-priority pixel reads with writes slotted into idle gaps.
// Optional write anti-starvation is enabled by defining SRAM_ARB_STARVE_EN.
module sram_bg_fetch_arbiter
    import sram_arb_pkg::*;
#(
    parameter logic [SRAM_AW-1:0] HOME_BASE    = 20'h00000,
    parameter logic [SRAM_AW-1:0] GAME_BASE    = 20'h40000,
    parameter int unsigned        READ_CYCLES  = 1,
    parameter int unsigned        WRITE_CYCLES = 2,
    parameter int unsigned        STARVE_LIMIT = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               gamescreen,
    input  logic               disp_req,
    input  logic [DISP_AW-1:0] disp_addr,
    output logic               disp_gnt,
    output logic               disp_valid,
    output logic [7:0]         disp_byte,
    input  logic               wr_req,
    input  logic [SRAM_AW-1:0] wr_addr,
    input  logic [SRAM_DW-1:0] wr_data,
    input  logic [1:0]         wr_be,
    output logic               wr_ack,
    output logic               busy,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_WE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ
);

    localparam int unsigned RdCntW = (READ_CYCLES > 1) ? $clog2(READ_CYCLES) : 1;
    localparam int unsigned WrCntW = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;

    arb_state_e         state_q, state_d;
    logic [RdCntW-1:0]  rd_cnt_q, rd_cnt_d;
    logic [WrCntW-1:0]  wr_cnt_q, wr_cnt_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [SRAM_DW-1:0] wdata_q, wdata_d;
    logic [1:0]         wbe_q, wbe_d;
    logic               lo_sel_q, lo_sel_d;
    logic               byte_lo_q, byte_lo_d;
    logic               disp_valid_q, disp_valid_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic               ub_n_q, ub_n_d;
    logic               lb_n_q, lb_n_d;
    logic               dq_oe_q, dq_oe_d;

    logic               rd_last, wr_last, accept_pt;
    logic               take_disp, take_wr, force_wr, capture;
    logic [SRAM_DW-1:0] rdata;

    assign rd_last   = (rd_cnt_q == RdCntW'(READ_CYCLES - 1));
    assign wr_last   = (wr_cnt_q == WrCntW'(WRITE_CYCLES - 1));
    assign accept_pt = (state_q == StIdle) || ((state_q == StRd) && rd_last);
    assign take_disp = accept_pt && disp_req && !force_wr;
    assign take_wr   = accept_pt && wr_req && !take_disp;

`ifdef SRAM_ARB_STARVE_EN
    localparam int unsigned      StarveW   = $clog2(STARVE_LIMIT + 1);
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

    logic [StarveW-1:0] starve_cnt_q, starve_cnt_d;

    assign force_wr = wr_req && (starve_cnt_q == StarveMax);

    // Counts display wins over a waiting write; saturates at the limit until the write goes.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (take_wr) begin
            starve_cnt_d = '0;
        end else if (take_disp && wr_req && (starve_cnt_q != StarveMax)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    logic unused_starve;

    assign force_wr      = 1'b0;
    assign unused_starve = |STARVE_LIMIT;
`endif

    always_comb begin
        state_d      = state_q;
        rd_cnt_d     = rd_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wbe_d        = wbe_q;
        lo_sel_d     = lo_sel_q;
        byte_lo_d    = byte_lo_q;
        disp_valid_d = 1'b0;
        disp_gnt     = 1'b0;
        capture      = 1'b0;

        case (state_q)
            StIdle: state_d = StIdle;
            StRd: begin
                if (rd_last) begin
                    capture      = 1'b1;
                    disp_valid_d = 1'b1;
                    byte_lo_d    = lo_sel_q;
                    state_d      = StIdle;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            StWrSetup: begin
                wr_cnt_d = '0;
                state_d  = StWr;
            end
            StWr: begin
                if (wr_last) begin
                    state_d = StWrHold;
                end else begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                end
            end
            StWrHold: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        if (take_disp) begin
            disp_gnt = 1'b1;
            state_d  = StRd;
            rd_cnt_d = '0;
            addr_d   = pixel_word_addr(gamescreen ? GAME_BASE : HOME_BASE, disp_addr);
            lo_sel_d = disp_addr[0];
        end else if (take_wr) begin
            state_d = StWrSetup;
            addr_d  = wr_addr;
            wdata_d = wr_data;
            wbe_d   = wr_be;
        end
    end

    // Pins are registered from the next state so they change cleanly on the clock edge.
    always_comb begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        case (state_d)
            StRd: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                ub_n_d = 1'b0;
                lb_n_d = 1'b0;
            end
            StWrSetup, StWr, StWrHold: begin
                ce_n_d  = 1'b0;
                we_n_d  = (state_d != StWr);
                ub_n_d  = ~wbe_d[1];
                lb_n_d  = ~wbe_d[0];
                dq_oe_d = 1'b1;
            end
            default: ce_n_d = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= StIdle;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wbe_q        <= '0;
            lo_sel_q     <= 1'b0;
            byte_lo_q    <= 1'b0;
            disp_valid_q <= 1'b0;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            ub_n_q       <= 1'b1;
            lb_n_q       <= 1'b1;
            dq_oe_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wbe_q        <= wbe_d;
            lo_sel_q     <= lo_sel_d;
            byte_lo_q    <= byte_lo_d;
            disp_valid_q <= disp_valid_d;
            ce_n_q       <= ce_n_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            ub_n_q       <= ub_n_d;
            lb_n_q       <= lb_n_d;
            dq_oe_q      <= dq_oe_d;
        end
    end

    sram_io_buf u_io (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .oe_i      (dq_oe_q),
        .wdata_i   (wdata_q),
        .capture_i (capture),
        .rdata_o   (rdata),
        .dq_io     (SRAM_DQ)
    );

    assign disp_valid = disp_valid_q;
    assign disp_byte  = byte_lo_q ? rdata[7:0] : rdata[15:8];
    assign wr_ack     = (state_q == StWrHold);
    assign busy       = (state_q != StIdle);
    assign SRAM_ADDR  = addr_q;
    assign SRAM_CE_N  = ce_n_q;
    assign SRAM_OE_N  = oe_n_q;
    assign SRAM_WE_N  = we_n_q;
    assign SRAM_UB_N  = ub_n_q;
    assign SRAM_LB_N  = lb_n_q;

endmodule

// File: tb/tb_sram_bg_fetch_arbiter.sv
// Scoreboard bench for sram_bg_fetch_arbiter with a behavioural async SRAM on the shared bus.
module tb_sram_bg_fetch_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        gamescreen, disp_req, wr_req;
    logic [18:0] disp_addr;
    logic [19:0] wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        disp_gnt, disp_valid, wr_ack, busy;
    logic [7:0]  disp_byte;
    logic [19:0] sram_addr;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
    wire  [15:0] sram_dq;

    always #5 clk = ~clk;

    sram_bg_fetch_arbiter dut (
        .Clk        (clk),
        .Reset      (rst),
        .gamescreen (gamescreen),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_gnt   (disp_gnt),
        .disp_valid (disp_valid),
        .disp_byte  (disp_byte),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .wr_ack     (wr_ack),
        .busy       (busy),
        .SRAM_ADDR  (sram_addr),
        .SRAM_CE_N  (sram_ce_n),
        .SRAM_OE_N  (sram_oe_n),
        .SRAM_WE_N  (sram_we_n),
        .SRAM_UB_N  (sram_ub_n),
        .SRAM_LB_N  (sram_lb_n),
        .SRAM_DQ    (sram_dq)
    );

    // SRAM model: reads settle mid-cycle, writes commit on the clock while WE_N is low.
    logic [15:0] mem [logic [19:0]];
    logic [15:0] mem_word;
    logic [15:0] mem_wr_tmp;
    wire         mem_drv = !sram_ce_n && !sram_oe_n && sram_we_n;

    assign sram_dq = mem_drv ? mem_word : 16'hzzzz;

    always @(negedge clk) mem_word <= mem.exists(sram_addr) ? mem[sram_addr] : 16'h0000;

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            mem_wr_tmp = mem.exists(sram_addr) ? mem[sram_addr] : 16'h0000;
            if (!sram_ub_n) mem_wr_tmp[15:8] = sram_dq[15:8];
            if (!sram_lb_n) mem_wr_tmp[7:0] = sram_dq[7:0];
            mem[sram_addr] = mem_wr_tmp;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int overlap = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { int cyc; logic [19:0] addr; } addr_exp_t;
    typedef struct { int cyc; logic [7:0]  b;    } byte_exp_t;

    addr_exp_t addr_q[$];
    byte_exp_t byte_q[$];
    int        ack_q[$];
    addr_exp_t ae;
    byte_exp_t be_e;
    int        ack_c;

    // Monitor: pops expectations whenever the DUT presents an address, a byte or an ack.
    always @(negedge clk) begin
        if (!rst) begin
            if (addr_q.size() > 0 && addr_q[0].cyc == cyc) begin
                ae = addr_q.pop_front();
                check("rd_addr", 32'(sram_addr), 32'(ae.addr));
                check("rd_pins", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}),
                      32'(5'b00100));
            end
            if (disp_valid) begin
                if (byte_q.size() == 0) begin
                    check("valid_unexpected", 32'(disp_valid), 32'(0));
                end else begin
                    be_e = byte_q.pop_front();
                    check("disp_byte", 32'(disp_byte), 32'(be_e.b));
                    check("valid_cycle", 32'(cyc), 32'(be_e.cyc));
                end
            end
            if (wr_ack) begin
                if (ack_q.size() == 0) begin
                    check("ack_unexpected", 32'(wr_ack), 32'(0));
                end else begin
                    ack_c = ack_q.pop_front();
                    check("ack_cycle", 32'(cyc), 32'(ack_c));
                end
            end
            if (dut.dq_oe_q && !sram_oe_n) overlap++;
        end
    end

    task automatic wait_gnt(output int c, output bit ok);
        ok = 1'b0;
        c  = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (disp_gnt) begin
                ok = 1'b1;
                c  = cyc;
                break;
            end
        end
        if (!ok) check("gnt_timeout", 32'(disp_gnt), 32'(1));
    endtask

    task automatic push_read(input logic [19:0] ea, input logic [7:0] eb, input int c);
        addr_q.push_back('{cyc: c + 1, addr: ea});
        byte_q.push_back('{cyc: c + 2, b: eb});
    endtask

    task automatic do_read(input bit gs, input logic [18:0] a, input logic [19:0] ea,
                           input logic [7:0] eb);
        int c;
        bit ok;
        @(posedge clk); #1;
        gamescreen = gs;
        disp_addr  = a;
        disp_req   = 1'b1;
        wait_gnt(c, ok);
        if (ok) push_read(ea, eb, c);
        @(posedge clk); #1;
        disp_req = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic do_write(input logic [19:0] a, input logic [15:0] d, input logic [1:0] be);
        @(posedge clk); #1;
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
        wr_req  = 1'b1;
        @(negedge clk);
        check("wr_accept_idle", 32'({busy, disp_gnt}), 32'(0));
        ack_q.push_back(cyc + 4);
        @(posedge clk); #1;
        wr_req = 1'b0;
        @(negedge clk);
        check("wr_setup_pins", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'(3'b011));
        check("wr_dq_driven", 32'(sram_dq), 32'(d));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("wr_pulse_pins", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}),
                  32'({3'b010, ~be}));
        end
        @(negedge clk);
        check("wr_hold_pins", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'(3'b011));
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  c, s, ngnt, exp_gnt;
        int  prev;
        bit  ok, wr_taken;
        logic [18:0] chain_a [4];
        logic [7:0]  chain_b [4];
        logic [19:0] chain_w [4];

        chain_a = '{19'h0, 19'h1, 19'h2, 19'h3};
        chain_b = '{8'hC3, 8'hA5, 8'h5A, 8'h7E};
        chain_w = '{20'h0, 20'h0, 20'h1, 20'h1};

        mem[20'h40002] = 16'hAB12;
        mem[20'h00000] = 16'hC3A5;
        mem[20'h00001] = 16'h5A7E;
        mem[20'h00010] = 16'h1234;
        mem[20'h00011] = 16'h7788;

        rst = 1'b1;
        gamescreen = 1'b0; disp_req = 1'b0; disp_addr = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;

        // 1: reset values, then 20 quiet cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", 32'({disp_gnt, disp_valid, wr_ack, busy, disp_byte}), 32'(0));
        check("rst_addr", 32'(sram_addr), 32'(0));
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_pins", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
                                    busy, dut.dq_oe_q}), 32'(7'b1111100));
        end

        // 2: game-screen low-byte fetch
        do_read(1'b1, 19'h00005, 20'h40002, 8'h12);

        // 3: back-to-back home-screen pixels
        @(posedge clk); #1;
        gamescreen = 1'b0;
        disp_req   = 1'b1;
        prev       = 0;
        for (int k = 0; k < 4; k++) begin
            disp_addr = chain_a[k];
            wait_gnt(c, ok);
            if (ok) push_read(chain_w[k], chain_b[k], c);
            if (k > 0) check("chain_gap", 32'(c - prev), 32'(1));
            prev = c;
            @(posedge clk); #1;
        end
        disp_req = 1'b0;
        repeat (4) @(posedge clk);

        // 4: upper-lane write, then read both bytes back; then a write with no lanes
        do_write(20'h00010, 16'hBEEF, 2'b10);
        do_read(1'b0, 19'h00020, 20'h00010, 8'hBE);
        do_read(1'b0, 19'h00021, 20'h00010, 8'h34);
        do_write(20'h00011, 16'hFFFF, 2'b00);
        do_read(1'b0, 19'h00022, 20'h00011, 8'h77);
        do_read(1'b0, 19'h00023, 20'h00011, 8'h88);

        // 5: display and write compete for 20 cycles
        @(posedge clk); #1;
        gamescreen = 1'b0;
        disp_addr  = 19'h0;
        wr_addr    = 20'h00030;
        wr_data    = 16'h0F0F;
        wr_be      = 2'b11;
        disp_req   = 1'b1;
        wr_req     = 1'b1;
        ngnt       = 0;
        wr_taken   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (disp_gnt) begin
                push_read(20'h00000, 8'hC3, cyc);
                ngnt++;
            end else if (!wr_taken && ngnt == 8) begin
                ack_q.push_back(cyc + 4);
                wr_taken = 1'b1;
            end
            @(posedge clk); #1;
            if (wr_taken) wr_req = 1'b0;
        end
        disp_req = 1'b0;
        if (!wr_taken) begin
            @(negedge clk);
            check("late_wr_no_gnt", 32'(disp_gnt), 32'(0));
            ack_q.push_back(cyc + 4);
            @(posedge clk); #1;
            wr_req = 1'b0;
        end
`ifdef SRAM_ARB_STARVE_EN
        exp_gnt = 15;
`else
        exp_gnt = 20;
`endif
        check("compete_gnts", 32'(ngnt), 32'(exp_gnt));
        repeat (8) @(posedge clk);

        // 6: reset in the middle of the WE_N pulse
        @(posedge clk); #1;
        wr_addr = 20'h00000;
        wr_data = 16'h5555;
        wr_be   = 2'b11;
        wr_req  = 1'b1;
        @(negedge clk);
        s = cyc;
        @(posedge clk); #1;
        wr_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_we_low", 32'({sram_we_n, s + 2 == cyc}), 32'(2'b01));
        #1 rst = 1'b1;
        #1;
        check("abort_pins", 32'({sram_ce_n, sram_oe_n, sram_we_n, dut.dq_oe_q, busy, wr_ack}),
              32'(6'b111000));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        do_read(1'b1, 19'h00004, 20'h40002, 8'hAB);
        do_read(1'b1, 19'h00005, 20'h40002, 8'h12);

        repeat (10) @(posedge clk);
        check("addr_q_empty", 32'(addr_q.size()), 32'(0));
        check("byte_q_empty", 32'(byte_q.size()), 32'(0));
        check("ack_q_empty", 32'(ack_q.size()), 32'(0));
        check("oe_dq_overlap", 32'(overlap), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
